// File: rtl/bconv_kxk_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bconv_kxk_engine                                            |
// | Description : Binary-weight KxK convolution engine. Accepts one tap       |
// |               column per handshake beat, keeps a KxK window, and computes |
// |               OC channels through a registered sign stage and adder tree. |
// |               Output qualification comes from row/column/phase counters.  |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module bconv_kxk_engine #(
    parameter int K  = 5,
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int OC = 1,
    parameter int S  = 1,
    parameter int WB = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             wt_start,
    input  logic             wt_valid,
    input  logic             wt_bit,
    output logic             wt_loaded,
    input  logic [WB-1:0]    cfg_w,
    input  logic [WB-1:0]    cfg_h,
    input  logic             start,
    input  logic             tap_valid,
    output logic             tap_ready,
    input  logic [K*DW-1:0]  taps,
    output logic [OC*AW-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int NT  = K * K;
    localparam int NW  = OC * NT;
    localparam int D   = $clog2(NT);
    localparam int LAT = 1 + D;
    localparam int N2  = 1 << D;
    localparam int IW  = $clog2(NW + 1);
    localparam int LW  = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IW-1:0]        r_widx;
    logic [NW-1:0]        r_wts;
    logic [WB-1:0]        r_cfg_w;
    logic [WB-1:0]        r_cfg_h;
    logic [WB-1:0]        r_col;
    logic [WB-1:0]        r_row;
    logic [1:0]           r_col_ph;
    logic [1:0]           r_row_ph;
    logic [LW-1:0]        r_drain_cnt;
    logic [LAT-1:0]       r_vq;
    logic signed [DW-1:0] r_win [NT];
    logic [OC*AW-1:0]     w_root;

    logic w_accept;
    logic w_last;
    logic w_qual;
    logic w_wt_begin;
    logic w_start_run;
    logic w_wt_take;
    logic w_wt_last;
    logic w_drain_end;

    function automatic logic signed [AW-1:0] sext(input logic [DW-1:0] p);
        return {{(AW-DW){p[DW-1]}}, p};
    endfunction

    // Event decode; tap_ready is a pure function of state so accept avoids a loop
    assign w_accept    = (r_state == RUN) && tap_valid;
    assign w_last      = (r_col == r_cfg_w - WB'(1)) && (r_row == r_cfg_h - WB'(1));
    assign w_qual      = w_accept && (r_col >= WB'(K-1)) && (r_row >= WB'(K-1))
                         && (r_col_ph == 2'd0) && (r_row_ph == 2'd0);
    assign w_wt_begin  = (r_state == IDLE) && wt_start;
    assign w_start_run = (r_state == IDLE) && !wt_start && start && wt_loaded;
    assign w_wt_take   = (r_state == LOAD) && wt_valid;
    assign w_wt_last   = w_wt_take && (r_widx == IW'(NW-1));
    assign w_drain_end = (r_state == DRAIN) && (r_drain_cnt == LW'(LAT-1));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state and state-decoded outputs; clr overrides every transition
    always_comb begin
        w_next    = r_state;
        tap_ready = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (wt_start)                w_next = LOAD;
                else if (start && wt_loaded) w_next = RUN;
            end
            LOAD: begin
                if (w_wt_last) w_next = IDLE;
            end
            RUN: begin
                tap_ready = 1'b1;
                busy      = 1'b1;
                if (w_accept && w_last) w_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_drain_end) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (clr) w_next = IDLE;
    end

    // Weight index and loaded flag; wt_loaded survives clr
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_widx    <= '0;
            wt_loaded <= 1'b0;
        end else if (clr) begin
            r_widx    <= '0;
        end else if (w_wt_begin) begin
            r_widx    <= '0;
            wt_loaded <= 1'b0;
        end else if (w_wt_take) begin
            r_widx <= r_widx + IW'(1);
            if (w_wt_last) wt_loaded <= 1'b1;
        end
    end

    // Weight storage is never cleared so a frame can rerun after an abort
    always_ff @(posedge clk) begin
        if (!clr && w_wt_take) r_wts[r_widx] <= wt_bit;
    end

    // Image size is captured at frame start and held for the whole frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cfg_w <= '0;
            r_cfg_h <= '0;
        end else if (!clr && w_start_run) begin
            r_cfg_w <= cfg_w;
            r_cfg_h <= cfg_h;
        end
    end

    // Raster position and stride phase; phases only run once past the K-1 margin
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col    <= '0;
            r_row    <= '0;
            r_col_ph <= '0;
            r_row_ph <= '0;
        end else if (clr || w_start_run) begin
            r_col    <= '0;
            r_row    <= '0;
            r_col_ph <= '0;
            r_row_ph <= '0;
        end else if (w_accept) begin
            if (r_col == r_cfg_w - WB'(1)) begin
                r_col    <= '0;
                r_col_ph <= '0;
                r_row    <= r_row + WB'(1);
                if (r_row >= WB'(K-1))
                    r_row_ph <= (r_row_ph == 2'(S-1)) ? 2'd0 : r_row_ph + 2'd1;
            end else begin
                r_col <= r_col + WB'(1);
                if (r_col >= WB'(K-1))
                    r_col_ph <= (r_col_ph == 2'(S-1)) ? 2'd0 : r_col_ph + 2'd1;
            end
        end
    end

    // Drain timer and end-of-frame pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_drain_cnt <= '0;
            done        <= 1'b0;
        end else begin
            done <= w_drain_end && !clr;
            if (!clr && (r_state == DRAIN)) r_drain_cnt <= r_drain_cnt + LW'(1);
            else                            r_drain_cnt <= '0;
        end
    end

    // Window shifts only on an accepted beat; the new column lands at c=K-1
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int t = 0; t < NT; t++) r_win[t] <= '0;
        end else if (w_accept && !clr) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K-1; c++) r_win[r*K+c] <= r_win[r*K+c+1];
                r_win[r*K+K-1] <= taps[(K-1-r)*DW +: DW];
            end
        end
    end

    // Qualifier shift register tracking results through the pipeline
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    r_vq <= '0;
        else if (clr) r_vq <= '0;
        else          r_vq <= {r_vq[LAT-2:0], w_qual};
    end

    // Result register: the last tree level adds straight into dout
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (clr) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= r_vq[LAT-1];
            if (r_vq[LAT-1]) dout <= w_root;
        end
    end

    for (genvar gc = 0; gc < OC; gc++) begin : g_ch
        logic signed [AW-1:0] w_leaf [N2];
        logic signed [AW-1:0] r_node [1:2*N2-2];

        // Signed terms; tree slots beyond K*K are padded with zero
        always_comb begin
            for (int t = 0; t < N2; t++) w_leaf[t] = '0;
            for (int t = 0; t < NT; t++)
                w_leaf[t] = r_wts[gc*NT+t] ? sext(r_win[t]) : -sext(r_win[t]);
        end

        // Heap-ordered tree: leaves are the sign stage, node n sums 2n+1 and 2n+2
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int n = 1; n <= 2*N2-2; n++) r_node[n] <= '0;
            end else begin
                for (int n = 1; n <= N2-2; n++) r_node[n] <= r_node[2*n+1] + r_node[2*n+2];
                for (int t = 0; t < N2; t++) r_node[N2-1+t] <= w_leaf[t];
            end
        end

        assign w_root[gc*AW +: AW] = r_node[1] + r_node[2];
    end

endmodule
`default_nettype wire

// File: tb/tb_bconv_kxk_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bconv_kxk_engine                                         |
// | Description : Directed bench for bconv_kxk_engine: a K=5/OC=1/S=1 unit    |
// |               and a K=5/OC=2/S=2 unit sharing the stimulus bus.           |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_bconv_kxk_engine;
    localparam int K   = 5;
    localparam int LAT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn, clr, wt_valid, wt_bit, tap_valid;
    logic         wt_start_a, wt_start_b, start_a, start_b;
    logic [7:0]   cfg_w, cfg_h;
    logic [159:0] taps;
    logic         wt_loaded_a, tap_ready_a, dout_valid_a, busy_a, done_a;
    logic [31:0]  dout_a;
    logic         wt_loaded_b, tap_ready_b, dout_valid_b, busy_b, done_b;
    logic [63:0]  dout_b;

    bconv_kxk_engine #(.K(5), .DW(32), .AW(32), .OC(1), .S(1), .WB(8)) u_dut_a (
        .clk(clk), .rstn(rstn), .clr(clr), .wt_start(wt_start_a), .wt_valid(wt_valid),
        .wt_bit(wt_bit), .wt_loaded(wt_loaded_a), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .start(start_a), .tap_valid(tap_valid), .tap_ready(tap_ready_a), .taps(taps),
        .dout(dout_a), .dout_valid(dout_valid_a), .busy(busy_a), .done(done_a)
    );

    bconv_kxk_engine #(.K(5), .DW(32), .AW(32), .OC(2), .S(2), .WB(8)) u_dut_b (
        .clk(clk), .rstn(rstn), .clr(clr), .wt_start(wt_start_b), .wt_valid(wt_valid),
        .wt_bit(wt_bit), .wt_loaded(wt_loaded_b), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .start(start_b), .tap_valid(tap_valid), .tap_ready(tap_ready_b), .taps(taps),
        .dout(dout_b), .dout_valid(dout_valid_b), .busy(busy_b), .done(done_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] got_q [$];
    int          got_cyc [$];
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          drain_cnt = 0;

    // Only one unit runs at a time, so both feed the same capture queues
    always @(negedge clk) begin
        if (dout_valid_a) begin got_q.push_back({32'd0, dout_a}); got_cyc.push_back(cyc); end
        if (dout_valid_b) begin got_q.push_back(dout_b); got_cyc.push_back(cyc); end
        if (done_a || done_b) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
        if ((busy_a && !tap_ready_a) || (busy_b && !tap_ready_b)) drain_cnt <= drain_cnt + 1;
    end

    logic [31:0] img [0:27][0:27];
    logic        wa   [0:49];
    logic        wb   [0:49];
    logic        wsrc [0:49];
    int          acc_first, acc_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] col_taps(input int r, input int c);
        logic [159:0] t;
        int y;
        t = '0;
        for (int i = 0; i < K; i++) begin
            y = r - (K-1) + i;
            if (y >= 0) t[(K-1-i)*32 +: 32] = img[y][c];
        end
        return t;
    endfunction

    function automatic logic [31:0] model(input int sel, input int oy, input int ox, input int ch);
        logic [31:0] acc;
        logic        w;
        acc = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w   = (sel != 0) ? wb[ch*25 + r*5 + c] : wa[r*5 + c];
                acc = w ? acc + img[oy+r][ox+c] : acc - img[oy+r][ox+c];
            end
        end
        return acc;
    endfunction

    task automatic load_w(input int sel, input int n);
        if (sel != 0) wt_start_b = 1'b1; else wt_start_a = 1'b1;
        @(posedge clk); #1;
        wt_start_a = 1'b0; wt_start_b = 1'b0;
        for (int i = 0; i < n; i++) begin
            wt_valid = 1'b1; wt_bit = wsrc[i];
            if (sel != 0) wb[i] = wsrc[i]; else wa[i] = wsrc[i];
            @(posedge clk); #1;
        end
        wt_valid = 1'b0;
    endtask

    task automatic run_frame(input int sel, input int w, input int h, input int duty, input int abort_row);
        int r, c, guard;
        logic v, rdy;
        r = 0; c = 0; guard = 0;
        cfg_w = 8'(w); cfg_h = 8'(h);
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        while (r < h && guard < 20000) begin
            if (r == abort_row && c == 0) begin
                clr = 1'b1; tap_valid = 1'b0;
                @(posedge clk); #1;
                clr = 1'b0;
                return;
            end
            v   = ($urandom_range(0, 99) < duty);
            tap_valid = v;
            taps      = col_taps(r, c);
            rdy = (sel != 0) ? tap_ready_b : tap_ready_a;
            @(posedge clk); #1;
            guard++;
            if (v && rdy) begin
                if (r == K-1 && c == K-1) acc_first = cyc;
                acc_last = cyc;
                c++;
                if (c == w) begin c = 0; r++; end
            end
        end
        tap_valid = 1'b0;
        if (r < h) chk("frame_timeout", 64'(r), 64'(h));
    endtask

    task automatic wait_done(input int base);
        int g;
        g = 0;
        while (done_cnt == base && g < 200) begin @(negedge clk); #1; g++; end
        chk("done_pulse", 64'(done_cnt - base), 64'd1);
    endtask

    task automatic check_frame(input int sel, input int base, input int w, input int h,
                               input int s, input string tag);
        int n;
        logic [63:0] e;
        n = 0;
        for (int oy = 0; oy <= h-K; oy += s) begin
            for (int ox = 0; ox <= w-K; ox += s) begin
                if (sel != 0) e = {model(1, oy, ox, 1), model(1, oy, ox, 0)};
                else          e = {32'd0, model(0, oy, ox, 0)};
                if (base + n < got_q.size()) chk(tag, got_q[base+n], e);
                n++;
            end
        end
        chk({tag, "_count"}, 64'(got_q.size() - base), 64'(n));
    endtask

    task automatic fill_img(input logic [31:0] val);
        for (int y = 0; y < 28; y++) for (int x = 0; x < 28; x++) img[y][x] = val;
    endtask

    int base, bd, bdr, b2, oy, ox;

    initial begin
        rstn = 1'b0; clr = 1'b0; wt_valid = 1'b0; wt_bit = 1'b0; tap_valid = 1'b0;
        wt_start_a = 1'b0; wt_start_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        cfg_w = 8'd12; cfg_h = 8'd12; taps = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wt_loaded", 64'(wt_loaded_a), 64'd0);
        chk("rst_tap_ready", 64'(tap_ready_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_dout_valid", 64'(dout_valid_a), 64'd0);
        chk("rst_dout", 64'(dout_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // start without weights is ignored
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        chk("nowt_busy", 64'(busy_a), 64'd0);
        chk("nowt_tap_ready", 64'(tap_ready_a), 64'd0);

        // all +1 weights, 28x28 frame of ones
        for (int i = 0; i < 50; i++) wsrc[i] = 1'b1;
        load_w(0, 25);
        chk("wt_loaded", 64'(wt_loaded_a), 64'd1);
        fill_img(32'd1);
        base = got_q.size(); bd = done_cnt; bdr = drain_cnt;
        run_frame(0, 28, 28, 100, -1);
        wait_done(bd);
        chk("ones28_count", 64'(got_q.size() - base), 64'd576);
        if (got_q.size() > base) begin
            chk("ones28_first_val", got_q[base], 64'd25);
            chk("first_latency", 64'(got_cyc[base] - acc_first), 64'(LAT));
        end
        check_frame(0, base, 28, 28, 1, "ones28");
        chk("done_timing", 64'(done_cyc - acc_last), 64'(LAT));
        chk("drain_cycles", 64'(drain_cnt - bdr), 64'(LAT));

        // all -1 weights on pixels of -1
        for (int i = 0; i < 50; i++) wsrc[i] = 1'b0;
        load_w(0, 25);
        fill_img(32'hFFFF_FFFF);
        base = got_q.size(); bd = done_cnt;
        run_frame(0, 6, 6, 100, -1);
        wait_done(bd);
        chk("neg_count", 64'(got_q.size() - base), 64'd4);
        for (int i = base; i < got_q.size(); i++) chk("neg_val", got_q[i], 64'd25);

        // wt_start beats a simultaneous start
        start_a = 1'b1; wt_start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; wt_start_a = 1'b0;
        chk("wtstart_wins_busy", 64'(busy_a), 64'd0);
        chk("wtstart_clears_loaded", 64'(wt_loaded_a), 64'd0);
        for (int i = 0; i < 50; i++) wsrc[i] = 1'b1;
        load_w(0, 25);
        fill_img(32'h7FFF_FFFF);
        base = got_q.size(); bd = done_cnt;
        run_frame(0, 5, 5, 100, -1);
        wait_done(bd);
        chk("wrap_count", 64'(got_q.size() - base), 64'd1);
        if (got_q.size() > base) chk("wrap_val", got_q[base], 64'h7FFF_FFE7);

        // random weights and pixels, back-to-back then 30% duty
        for (int i = 0; i < 50; i++) wsrc[i] = 1'($urandom_range(0, 1));
        load_w(0, 25);
        for (int y = 0; y < 28; y++) for (int x = 0; x < 28; x++) img[y][x] = $urandom;
        base = got_q.size(); bd = done_cnt;
        run_frame(0, 12, 12, 100, -1);
        wait_done(bd);
        check_frame(0, base, 12, 12, 1, "rand_full");
        base = got_q.size(); bd = done_cnt; bdr = drain_cnt;
        run_frame(0, 12, 12, 30, -1);
        wait_done(bd);
        check_frame(0, base, 12, 12, 1, "rand_duty");
        chk("duty_drain_cycles", 64'(drain_cnt - bdr), 64'(LAT));

        // abort at row 7, then rerun on retained weights
        bd = done_cnt;
        run_frame(0, 12, 12, 100, 7);
        chk("clr_busy", 64'(busy_a), 64'd0);
        chk("clr_tap_ready", 64'(tap_ready_a), 64'd0);
        b2 = got_q.size();
        repeat (20) @(posedge clk);
        #1;
        chk("clr_no_dout", 64'(got_q.size() - b2), 64'd0);
        chk("clr_no_done", 64'(done_cnt - bd), 64'd0);
        chk("clr_keeps_loaded", 64'(wt_loaded_a), 64'd1);
        base = got_q.size(); bd = done_cnt;
        run_frame(0, 12, 12, 100, -1);
        wait_done(bd);
        check_frame(0, base, 12, 12, 1, "retained");

        // two channels, stride 2, ramp image: closed-form sums
        for (int i = 0; i < 50; i++) wsrc[i] = (i < 25) ? 1'b1 : 1'(((i - 25) % 2) == 0);
        load_w(1, 50);
        chk("b_wt_loaded", 64'(wt_loaded_b), 64'd1);
        for (int y = 0; y < 28; y++) for (int x = 0; x < 28; x++) img[y][x] = 32'(y*12 + x);
        base = got_q.size(); bd = done_cnt;
        run_frame(1, 12, 12, 100, -1);
        wait_done(bd);
        chk("ramp_count", 64'(got_q.size() - base), 64'd16);
        for (int i = 0; i < 16 && base + i < got_q.size(); i++) begin
            oy = 2 * (i / 4); ox = 2 * (i % 4);
            chk("ramp_val", got_q[base+i], {32'(26 + 12*oy + ox), 32'(650 + 25*(12*oy + ox))});
        end

        // two channels, stride 2, random weights and pixels with gaps
        for (int i = 0; i < 50; i++) wsrc[i] = 1'($urandom_range(0, 1));
        load_w(1, 50);
        for (int y = 0; y < 28; y++) for (int x = 0; x < 28; x++) img[y][x] = $urandom;
        base = got_q.size(); bd = done_cnt;
        run_frame(1, 12, 12, 30, -1);
        wait_done(bd);
        check_frame(1, base, 12, 12, 2, "s2_rand");

        // asynchronous reset in the middle of a frame
        cfg_w = 8'd12; cfg_h = 8'd12;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        tap_valid = 1'b1; taps = {5{32'd3}};
        repeat (80) @(posedge clk);
        #1;
        chk("pre_rst_dout_nonzero", 64'(dout_a != 32'd0), 64'd1);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_dout", 64'(dout_a), 64'd0);
        chk("arst_dout_valid", 64'(dout_valid_a), 64'd0);
        chk("arst_busy", 64'(busy_a), 64'd0);
        chk("arst_tap_ready", 64'(tap_ready_a), 64'd0);
        chk("arst_wt_loaded", 64'(wt_loaded_a), 64'd0);
        chk("arst_done", 64'(done_a), 64'd0);
        tap_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bconv_kxk_engine.md
Name: bconv_kxk_engine

Overview:
- Parametrised binary-weight KxK convolution engine. Successor to the fixed 5x5, single-channel, cycle-count-timed conv stage.
- Consumes one KxK-row tap column per accepted beat from the line-buffer/window feeder.
- Computes OC output channels in parallel from the same window, with runtime image size and parameter stride.
- Output validity comes from row/column counters and a tap valid/ready handshake, not from fixed cycle counts.

Parameters:
- K, 5, kernel side length (3..7).
- DW, 32, signed input pixel width.
- AW, 32, signed accumulator/output width per channel; must be >= DW+clog2(K*K)+1.
- OC, 1, output channels computed in parallel.
- S, 1, stride (1 or 2), applied in both dimensions.
- WB, 8, width of the runtime image-size configuration fields.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous abort; returns to IDLE and flushes the pipeline.
- wt_start  in  1  pulse; clears the weight index and enters LOAD.
- wt_valid  in  1  a weight bit is present on wt_bit.
- wt_bit  in  1  serial weight; 1 = +1, 0 = -1.
- wt_loaded  out  1  high once all OC*K*K bits have been loaded since the last wt_start.
- cfg_w  in  WB  image width (columns), >= K.
- cfg_h  in  WB  image height (rows), >= K.
- start  in  1  pulse; begins a frame.
- tap_valid  in  1  tap column present.
- tap_ready  out  1  engine accepts a tap column.
- taps  in  K*DW  tap column; row 0 (top) in MSBs, row K-1 in LSBs.
- dout  out  OC*AW  results; channel 0 in LSBs.
- dout_valid  out  1  dout valid for one cycle.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (rstn low, async) and clr:
  - state=IDLE; wt_loaded=0; tap_ready=0; dout=0; dout_valid=0; busy=0; done=0.
  - All counters and the valid pipeline are cleared.
  - Weight storage is not cleared. wt_loaded is cleared by rstn only, not by clr.
- FSM states: IDLE, LOAD, RUN, DRAIN.
  - IDLE -> LOAD on wt_start.
  - IDLE -> RUN on start when wt_loaded=1; cfg_w and cfg_h are latched at this point.
  - start while wt_loaded=0 is ignored. wt_start and start in the same cycle: wt_start wins.
  - LOAD: each wt_valid writes wt_bit at index i, then i++. Index order: i = oc*K*K + r*K + c, with c=0 the oldest column.
  - At i = OC*K*K-1 accepted: wt_loaded=1, go to IDLE. Further wt_valid outside LOAD is ignored.
  - RUN: tap_ready=1. Accept = tap_valid & tap_ready.
  - DRAIN: entered after the last column (col=cfg_w-1, row=cfg_h-1) is accepted. tap_ready=0.
  - DRAIN lasts LAT cycles, then done=1 for one cycle and state returns to IDLE.
- Window:
  - On accept only, the KxK window shifts left by one column and the new column enters at c=K-1.
  - No shift without accept, so stalls are lossless.
- Counters:
  - col runs 0..cfg_w-1 and wraps to 0, incrementing row; both advance on accept.
  - The window does not reset at row wrap. Columns from the previous row are flushed by the col gating below.
- Output gating: an accepted column produces a result iff all of the following hold:
  - col >= K-1 and row >= K-1;
  - (col-(K-1)) mod S == 0;
  - (row-(K-1)) mod S == 0.
  - Phase counters are used for the mod checks (no dividers).
  - Outputs per frame = ((cfg_w-K)/S+1) * ((cfg_h-K)/S+1), integer division.
- Arithmetic:
  - Each window pixel is sign-extended to AW, then added when the weight bit is 1 and negated when it is 0.
  - Sum over the K*K terms, wrapping modulo 2^AW; no saturation.
- Pipeline and latency:
  - 1 registered sign stage, then a registered binary adder tree of depth clog2(K*K).
  - LAT = 1 + clog2(K*K), which is 6 for K=5.
  - dout_valid and dout appear exactly LAT cycles after the accepting edge of the qualifying column (shift register of qualifiers).
  - The pipeline advances every cycle and has no backpressure.
  - dout holds its last value when dout_valid=0.
- Other:
  - busy = RUN|DRAIN.
  - clr in any state aborts with no done pulse.
  - start during RUN/DRAIN is ignored.
  - cfg_* changes during RUN have no effect.

Test Plan:
- K=5, OC=1: load 25 ones; 28x28 frame of pixel=1, tap_valid always high -> 576 dout_valid pulses, each 25; first pulse 6 cycles after accept of col=4,row=4; done one cycle after DRAIN ends.
- Weights all 0, pixels=-1 -> every dout=+25. Then pixels=2^31-1 with all-1 weights -> dout wraps to 0x7FFFFFE7.
- cfg_w=cfg_h=12, S=2 build -> exactly 16 outputs, at window origins (0,0),(0,2)..(6,6). Values checked against a golden model with random weights and pixels.
- Random tap_valid duty (30%) on a 12x12 frame -> dout sequence identical to the back-to-back run; tap_ready=0 in DRAIN.
- Second stage:
  - OC=2, weights ch0 all 1, ch1 alternating 1/0: dout[31:0]=sum and dout[63:32]=alternating-sign sum on a ramp image.
  - start with wt_loaded=0 is ignored; busy stays 0.
- Abort cases:
  - clr mid-frame (row 7) -> next cycle IDLE, no further dout_valid, no done; a new start without reload runs with the retained weights.
  - rstn low mid-run -> all outputs 0 asynchronously.
